// File: rtl/mem_port_arbiter_if.sv
// CPU / debug request ports and memory port of mem_port_arbiter, grouped as one bundle.
// slave: the arbiter's view; master: the requester/memory side.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_done;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic              dbg_gnt;
  logic              dbg_done;
  logic [DATA_W-1:0] dbg_rdata;

  logic              mem_en;
  logic              mem_ren;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  logic              busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, dbg_req, dbg_addr, mem_dout,
    output cpu_gnt, cpu_done, cpu_rdata, dbg_gnt, dbg_done, dbg_rdata,
    output mem_en, mem_ren, mem_wen, mem_addr, mem_din, busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, dbg_req, dbg_addr, mem_dout,
    input  cpu_gnt, cpu_done, cpu_rdata, dbg_gnt, dbg_done, dbg_rdata,
    input  mem_en, mem_ren, mem_wen, mem_addr, mem_din, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester (CPU read/write, debug read-only) arbiter for one memory port, registered outputs.
// Define ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests; otherwise the CPU always wins.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 3
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StAccess, StWait, StResp} state_e;

  // Edges counted from ACCESS entry: data capture edge, then RESP entry edge.
  localparam logic [4:0] LatEdge = 5'(RD_LAT);
  localparam logic [4:0] LatDone = 5'(RD_LAT + 1);

  state_e            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              win_dbg_q, win_dbg_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] hold_q, hold_d;

  logic              cpu_gnt_q, cpu_gnt_d, dbg_gnt_q, dbg_gnt_d;
  logic              cpu_done_q, cpu_done_d, dbg_done_q, dbg_done_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d, dbg_rdata_q, dbg_rdata_d;
  logic              mem_en_q, mem_en_d, mem_ren_q, mem_ren_d, mem_wen_q, mem_wen_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_din_q, mem_din_d;
  logic              busy_q, busy_d;

  logic              pick_dbg;
  logic              new_we;

`ifdef ARB_ROUND_ROBIN_EN
  logic              last_dbg_q, last_dbg_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    win_dbg_d   = win_dbg_q;
    we_d        = we_q;
    hold_d      = hold_q;
    cpu_gnt_d   = 1'b0;
    dbg_gnt_d   = 1'b0;
    cpu_done_d  = 1'b0;
    dbg_done_d  = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    mem_en_d    = mem_en_q;
    mem_ren_d   = mem_ren_q;
    mem_wen_d   = mem_wen_q;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_dbg_d  = last_dbg_q;
    pick_dbg    = bus.dbg_req & (~bus.cpu_req | ~last_dbg_q);
`else
    pick_dbg    = bus.dbg_req & ~bus.cpu_req;
`endif
    new_we      = ~pick_dbg & bus.cpu_we;

    unique case (state_q)
      StIdle: begin
        if (bus.cpu_req || bus.dbg_req) begin
          state_d    = StAccess;
          cnt_d      = '0;
          win_dbg_d  = pick_dbg;
          we_d       = new_we;
          cpu_gnt_d  = ~pick_dbg;
          dbg_gnt_d  = pick_dbg;
          mem_en_d   = 1'b1;
          mem_ren_d  = ~new_we;
          mem_wen_d  = new_we;
          mem_addr_d = pick_dbg ? bus.dbg_addr : bus.cpu_addr;
          mem_din_d  = new_we ? bus.cpu_wdata : '0;
`ifdef ARB_ROUND_ROBIN_EN
          last_dbg_d = pick_dbg;
`endif
        end
      end
      StAccess, StWait: begin
        cnt_d = cnt_q + 5'd1;
        if (we_q) begin
          state_d    = StResp;
          mem_en_d   = 1'b0;
          mem_wen_d  = 1'b0;
          cpu_done_d = 1'b1;
        end else begin
          state_d = StWait;
          if (cnt_d == LatEdge) begin
            hold_d    = bus.mem_dout;
            mem_en_d  = 1'b0;
            mem_ren_d = 1'b0;
          end
          if (cnt_d == LatDone) begin
            state_d    = StResp;
            cpu_done_d = ~win_dbg_q;
            dbg_done_d = win_dbg_q;
            if (win_dbg_q) dbg_rdata_d = hold_q;
            else           cpu_rdata_d = hold_q;
          end
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      win_dbg_q   <= 1'b0;
      we_q        <= 1'b0;
      hold_q      <= '0;
      cpu_gnt_q   <= 1'b0;
      dbg_gnt_q   <= 1'b0;
      cpu_done_q  <= 1'b0;
      dbg_done_q  <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
      mem_en_q    <= 1'b0;
      mem_ren_q   <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      busy_q      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_dbg_q  <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      win_dbg_q   <= win_dbg_d;
      we_q        <= we_d;
      hold_q      <= hold_d;
      cpu_gnt_q   <= cpu_gnt_d;
      dbg_gnt_q   <= dbg_gnt_d;
      cpu_done_q  <= cpu_done_d;
      dbg_done_q  <= dbg_done_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_ren_q   <= mem_ren_d;
      mem_wen_q   <= mem_wen_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      busy_q      <= busy_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_dbg_q  <= last_dbg_d;
`endif
    end
  end

  assign bus.cpu_gnt   = cpu_gnt_q;
  assign bus.dbg_gnt   = dbg_gnt_q;
  assign bus.cpu_done  = cpu_done_q;
  assign bus.dbg_done  = dbg_done_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dbg_rdata = dbg_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_ren   = mem_ren_q;
  assign bus.mem_wen   = mem_wen_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_din   = mem_din_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table of single accesses plus arbitration,
// reset-abort and RD_LAT=1 sequences.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(32)) bus ();
  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(32)) bus1 ();

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .RD_LAT(3)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .RD_LAT(1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  function automatic logic [31:0] mem_model(input logic [15:0] a);
    return (a == 16'h0010) ? 32'hDEADBEEF : {16'hA5A5, a};
  endfunction

  assign bus.mem_dout  = mem_model(bus.mem_addr);
  assign bus1.mem_dout = mem_model(bus1.mem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Mutual exclusion of strobes, grants and dones on the main DUT.
  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if ((bus.mem_ren && bus.mem_wen) || (bus.cpu_gnt && bus.dbg_gnt) ||
          (bus.cpu_done && bus.dbg_done)) begin
        errors++;
        $display("FAIL exclusive: ren=%b wen=%b gnt=%b%b done=%b%b", bus.mem_ren, bus.mem_wen,
                 bus.cpu_gnt, bus.dbg_gnt, bus.cpu_done, bus.dbg_done);
      end
    end
  end

  typedef struct {
    logic        is_dbg;
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] exp_rdata;
    int          ren_cyc;
    int          wen_cyc;
    logic [31:0] exp_din;
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic all_zero(input string tag);
    check({tag, " strobes"}, 32'({bus.cpu_gnt, bus.cpu_done, bus.dbg_gnt, bus.dbg_done,
                                  bus.mem_en, bus.mem_ren, bus.mem_wen, bus.busy}), 32'h0);
    check({tag, " cpu_rdata"}, bus.cpu_rdata, 32'h0);
    check({tag, " dbg_rdata"}, bus.dbg_rdata, 32'h0);
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int n, m, ren_c, wen_c, addr_bad;
    logic [31:0] din_seen;
    logic got;
    if (v.is_dbg) begin
      bus.dbg_req  = 1'b1;
      bus.dbg_addr = v.addr;
    end else begin
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = v.we;
      bus.cpu_addr  = v.addr;
      bus.cpu_wdata = v.wdata;
    end
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      step();
      n++;
      got = v.is_dbg ? bus.dbg_gnt : bus.cpu_gnt;
    end
    check({tag, " gnt_lat"}, 32'(n), 32'd1);
    check({tag, " busy"}, 32'(bus.busy), 32'd1);
    // Drop the request and scramble every request input; all must be ignored.
    bus.cpu_req   = 1'b0;
    bus.dbg_req   = 1'b0;
    bus.cpu_addr  = ~v.addr;
    bus.dbg_addr  = ~v.addr;
    bus.cpu_wdata = ~v.wdata;
    bus.cpu_we    = ~v.we;
    ren_c = 0; wen_c = 0; addr_bad = 0; din_seen = '0; m = 0; got = 1'b0;
    while (!got && m < 30) begin
      if (bus.mem_ren) ren_c++;
      if (bus.mem_wen) begin
        wen_c++;
        din_seen = bus.mem_din;
      end
      if (bus.mem_en && bus.mem_addr !== v.addr) addr_bad++;
      step();
      m++;
      got = v.is_dbg ? bus.dbg_done : bus.cpu_done;
    end
    check({tag, " done_lat"}, 32'(m), 32'(v.lat));
    check({tag, " ren_cycles"}, 32'(ren_c), 32'(v.ren_cyc));
    check({tag, " wen_cycles"}, 32'(wen_c), 32'(v.wen_cyc));
    check({tag, " mem_din"}, din_seen, v.exp_din);
    check({tag, " mem_addr_stable"}, 32'(addr_bad), 32'd0);
    check({tag, " rdata"}, v.is_dbg ? bus.dbg_rdata : bus.cpu_rdata, v.exp_rdata);
    step();
    check({tag, " done_pulse"}, 32'({bus.cpu_done, bus.dbg_done, bus.busy}), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int n, k, m, pulses;
    int gseq[3];
    int gtime[3];
    int exp_seq[3];
    vec_t v;

    vecs[0] = '{1'b0, 1'b0, 16'h0010, 32'h0,        4, 32'hDEADBEEF, 3, 0, 32'h0};
    vecs[1] = '{1'b0, 1'b1, 16'h189C, 32'h12345678, 1, 32'hDEADBEEF, 0, 1, 32'h12345678};
    vecs[2] = '{1'b1, 1'b0, 16'h0020, 32'h0,        4, 32'hA5A50020, 3, 0, 32'h0};
    vecs[3] = '{1'b0, 1'b0, 16'h1234, 32'h0,        4, 32'hA5A51234, 3, 0, 32'h0};
    vecs[4] = '{1'b1, 1'b0, 16'hFFFF, 32'h0,        4, 32'hA5A5FFFF, 3, 0, 32'h0};
    vecs[5] = '{1'b0, 1'b1, 16'h0000, 32'hFFFFFFFF, 1, 32'hA5A51234, 0, 1, 32'hFFFFFFFF};

    {bus.cpu_req, bus.cpu_we, bus.dbg_req} = '0;
    bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.dbg_addr = '0;
    {bus1.cpu_req, bus1.cpu_we, bus1.dbg_req} = '0;
    bus1.cpu_addr = '0; bus1.cpu_wdata = '0; bus1.dbg_addr = '0;
    reset = 1'b1;
    step();
    step();
    all_zero("reset");
    check("reset mem_addr", 32'(bus.mem_addr), 32'h0);
    check("reset mem_din", bus.mem_din, 32'h0);
    reset = 1'b0;
    step();
    check("idle busy", 32'(bus.busy), 32'd0);

    for (int i = 0; i < 6; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Simultaneous held reads right after reset.
    reset = 1'b1;
    #2;
    reset = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0030;
    bus.dbg_req = 1'b1; bus.dbg_addr = 16'h0040;
    k = 0; n = 0;
    while (k < 3 && n < 60) begin
      step();
      n++;
      if (bus.cpu_gnt) begin gseq[k] = 0; gtime[k] = n; k++; end
      else if (bus.dbg_gnt) begin gseq[k] = 1; gtime[k] = n; k++; end
    end
    bus.cpu_req = 1'b0;
    bus.dbg_req = 1'b0;
    check("arb grant_count", 32'(k), 32'd3);
`ifdef ARB_ROUND_ROBIN_EN
    exp_seq = '{0, 1, 0};
`else
    exp_seq = '{0, 0, 0};
`endif
    for (int i = 0; i < 3; i++) check($sformatf("arb grant%0d", i), 32'(gseq[i]), 32'(exp_seq[i]));
    check("arb read_period", 32'(gtime[1] - gtime[0]), 32'd6);
    m = 0;
    while (bus.busy && m < 20) begin step(); m++; end
    check("arb drain", 32'(bus.busy), 32'd0);
    step();

    // Reset in the second WAIT cycle of a dbg read.
    bus.dbg_req = 1'b1;
    bus.dbg_addr = 16'h0060;
    n = 0;
    while (!bus.dbg_gnt && n < 20) begin step(); n++; end
    check("rst gnt_lat", 32'(n), 32'd1);
    bus.dbg_req = 1'b0;
    step();
    step();
    check("rst pre busy", 32'(bus.busy & bus.mem_ren), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    all_zero("rst async");
    pulses = 0;
    for (int i = 0; i < 2; i++) begin step(); if (bus.dbg_done) pulses++; end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin step(); if (bus.dbg_done || bus.busy) pulses++; end
    check("rst no_done", 32'(pulses), 32'd0);
    v = '{1'b1, 1'b0, 16'h0042, 32'h0, 4, 32'hA5A50042, 3, 0, 32'h0};
    run_txn(v, "post_rst");

    // RD_LAT = 1 instance.
    bus1.cpu_req = 1'b1;
    bus1.cpu_we = 1'b0;
    bus1.cpu_addr = 16'h0010;
    n = 0;
    while (!bus1.cpu_gnt && n < 20) begin step(); n++; end
    check("lat1 gnt_lat", 32'(n), 32'd1);
    bus1.cpu_req = 1'b0;
    bus1.cpu_addr = 16'h0011;
    m = 0; k = 0;
    while (!bus1.cpu_done && m < 20) begin
      if (bus1.mem_ren) k++;
      step();
      m++;
    end
    check("lat1 done_lat", 32'(m), 32'd2);
    check("lat1 ren_cycles", 32'(k), 32'd1);
    check("lat1 rdata", bus1.cpu_rdata, 32'hDEADBEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
